uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo_pkg.sv | 21 ++
 rtl/uart_byte_fifo.sv | 61 ++++++
 rtl/uart_rx_fifo.sv | 142 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART definitions: deframer state encoding and baud divisor derivation.
// The transmit side reuses the same constants.
package uart_rx_fifo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    localparam int unsigned DEF_CLK_HZ = 25_000_000;
    localparam int unsigned DEF_BAUD   = 115_200;

    // Rounded clocks-per-bit; 25 MHz / 115200 gives 217.
    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Circular byte FIFO with a separate level counter. A push while full is only
// taken if a pop frees the head in the same cycle; otherwise it is dropped.
module uart_byte_fifo #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [7:0]    din_i,
    input  logic          pop_i,
    output logic [7:0]    dout_o,
    output logic [AW:0]   level_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          drop_o
);

    localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

    logic [7:0]    mem_q [2**AW];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   level_q, level_d;
    logic          do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == DEPTH);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | pop_i);
    assign drop_o  = push_i & full_o & ~pop_i;

    always_comb begin
        wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
        level_d = level_q;
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

    assign dout_o  = empty_o ? 8'h00 : mem_q[rptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: synchroniser, oversampling deframer, byte FIFO,
// sticky error flags and hysteretic RTS flow control.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned CLK_HZ = DEF_CLK_HZ,
    parameter int unsigned BAUD   = DEF_BAUD,
    parameter int          AW     = 4,
    parameter int          RTS_HI = 12,
    parameter int          RTS_LO = 4
) (
    input  logic          clk25mhz,
    input  logic          rst_n,
    input  logic          uart_rx,
    input  logic          rd_pop,
    input  logic          clr_err,
    output logic [7:0]    rx_data,
    output logic          rx_avail,
    output logic [AW:0]   rx_level,
    output logic          rx_overflow,
    output logic          framing_err,
    output logic          uart_rts
);

    localparam int unsigned DIV  = baud_div(CLK_HZ, BAUD);
    localparam int unsigned HALF = DIV / 2;
    localparam logic [7:0]  CNT_FULL = 8'(DIV - 1);
    localparam logic [7:0]  CNT_HALF = 8'(HALF - 1);
    localparam logic [AW:0] LVL_HI   = (AW+1)'(RTS_HI);
    localparam logic [AW:0] LVL_LO   = (AW+1)'(RTS_LO);

    rx_state_e   state_q, state_d;
    logic        rx_meta_q, rxs_q, rxs_prev_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sreg_q, sreg_d;
    logic        ovf_q, ovf_d, ferr_q, ferr_d, rts_q, rts_d;
    logic        push, ferr_set, fifo_drop;
    logic        fifo_full, fifo_empty;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 8'd1;
        bit_d    = bit_q;
        sreg_d   = sreg_q;
        push     = 1'b0;
        ferr_set = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (rxs_prev_q && !rxs_q) state_d = ST_START;
            end
            ST_START: begin
                // Mid start bit: a line back high was only a glitch.
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxs_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d  = '0;
                    sreg_d = {rxs_q, sreg_q[7:1]};
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                cnt_d = '0;
                if (rxs_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Set events beat a simultaneous clear so no error is ever lost.
    always_comb begin
        ovf_d  = fifo_drop | (ovf_q & ~clr_err);
        ferr_d = ferr_set  | (ferr_q & ~clr_err);
        rts_d  = rts_q;
        if (rx_level >= LVL_HI)      rts_d = 1'b1;
        else if (rx_level <= LVL_LO) rts_d = 1'b0;
    end

    always_ff @(posedge clk25mhz or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            sreg_q     <= '0;
            ovf_q      <= 1'b0;
            ferr_q     <= 1'b0;
            rts_q      <= 1'b0;
        end else begin
            rx_meta_q  <= uart_rx;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            sreg_q     <= sreg_d;
            ovf_q      <= ovf_d;
            ferr_q     <= ferr_d;
            rts_q      <= rts_d;
        end
    end

    uart_byte_fifo #(.AW(AW)) u_fifo (
        .clk     (clk25mhz),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   (sreg_q),
        .pop_i   (rd_pop),
        .dout_o  (rx_data),
        .level_o (rx_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .drop_o  (fifo_drop)
    );

    assign rx_avail    = ~fifo_empty;
    assign rx_overflow = ovf_q;
    assign framing_err = ferr_q;
    assign uart_rts    = rts_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised and directed frames against a queue-based receiver model.
module tb_uart_rx_fifo;

    localparam int CLK_HZ = 25_000_000;
    localparam int DIV    = 40;
    localparam int HALF   = DIV / 2;
    localparam int BAUD   = CLK_HZ / DIV;
    // Clock edges from start-bit drive to the stop-bit push: 2 sync flops,
    // 1 edge-detect cycle, HALF to mid start bit, then 9 bit periods.
    localparam int PUSH_AT = HALF + 3 + 9 * DIV;

    logic       clk = 1'b0, rst_n = 1'b0, uart_rx = 1'b1, rd_pop = 1'b0, clr_err = 1'b0;
    logic [7:0] rx_data;
    logic       rx_avail, rx_overflow, framing_err, uart_rts;
    logic [4:0] rx_level;

    logic [7:0] mq[$];
    bit         m_ovf = 0, m_ferr = 0, m_rts = 0;
    int         n_chk = 0, n_fail = 0;

    uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .AW(4), .RTS_HI(12), .RTS_LO(4)) dut (
        .clk25mhz    (clk),
        .rst_n       (rst_n),
        .uart_rx     (uart_rx),
        .rd_pop      (rd_pop),
        .clr_err     (clr_err),
        .rx_data     (rx_data),
        .rx_avail    (rx_avail),
        .rx_level    (rx_level),
        .rx_overflow (rx_overflow),
        .framing_err (framing_err),
        .uart_rts    (uart_rts)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void m_rts_upd();
        if (mq.size() >= 12)     m_rts = 1;
        else if (mq.size() <= 4) m_rts = 0;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "/data"},  32'(rx_data),     mq.size() != 0 ? 32'(mq[0]) : 32'd0);
        chk({tag, "/avail"}, 32'(rx_avail),    32'(mq.size() != 0));
        chk({tag, "/level"}, 32'(rx_level),    32'(mq.size()));
        chk({tag, "/ovf"},   32'(rx_overflow), 32'(m_ovf));
        chk({tag, "/ferr"},  32'(framing_err), 32'(m_ferr));
        chk({tag, "/rts"},   32'(uart_rts),    32'(m_rts));
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop, input bit pop_at_push,
                              input int hold, output int lat);
        logic [9:0] fr;
        fr  = {stop, b, 1'b0};
        lat = -1;
        for (int c = 0; c < 10 * DIV; c++) begin
            if (lat < 0 && c > 0 && rx_avail) lat = c;
            uart_rx = fr[c / DIV];
            rd_pop  = pop_at_push && (c == PUSH_AT - 1);
            @(negedge clk);
        end
        rd_pop = 1'b0;
        repeat (hold) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
        if (stop) begin
            if (pop_at_push && mq.size() != 0) void'(mq.pop_front());
            if (mq.size() < 16) mq.push_back(b);
            else                m_ovf = 1;
        end else begin
            m_ferr = 1;
        end
        m_rts_upd();
        check_all("frame");
    endtask

    task automatic do_pop();
        rd_pop = 1'b1;
        @(negedge clk);
        rd_pop = 1'b0;
        @(negedge clk);
        if (mq.size() != 0) void'(mq.pop_front());
        m_rts_upd();
        check_all("pop");
    endtask

    task automatic do_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
        m_ovf  = 0;
        m_ferr = 0;
        check_all("clr");
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        logic [7:0] b;
        bit         stop;

        repeat (3) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send_frame(8'h55, 1, 0, 0, lat);
        chk("latency", 32'(lat), 32'(PUSH_AT));
        send_frame(8'hA3, 1, 0, 0, lat);
        do_pop();

        uart_rx = 1'b0;
        repeat (HALF / 2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        check_all("glitch");

        send_frame(8'h3C, 0, 0, 1000, lat);
        send_frame(8'h3C, 1, 0, 0, lat);
        do_clr();
        while (mq.size() != 0) do_pop();

        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1, 0, 0, lat);
        repeat (16) do_pop();
        do_clr();
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1, i == 16, 0, lat);
        while (mq.size() != 0) do_pop();

        repeat (24) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            send_frame(b, stop, 0, stop ? 0 : int'($urandom_range(DIV, 4 * DIV)), lat);
            repeat ($urandom_range(0, 2)) do_pop();
            if ($urandom_range(0, 3) == 0) do_clr();
        end

        send_frame(8'h11, 1, 0, 0, lat);
        send_frame(8'h22, 0, 0, DIV, lat);
        uart_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        uart_rx = 1'b1;
        repeat (DIV) @(negedge clk);
        uart_rx = 1'b0;
        repeat (2 * DIV) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        mq.delete();
        m_ovf  = 0;
        m_ferr = 0;
        m_rts  = 0;
        check_all("in_reset");
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        check_all("post_reset");
        send_frame(8'h81, 1, 0, 0, lat);
        chk("post_reset_lat", 32'(lat), 32'(PUSH_AT));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
